// File: rtl/hazard_scanner.sv
// hazard_scanner: once per frame, probes three map points around each
// character's feet through one shared synchronous ROM port, classifies the
// returned colours and debounces per-character hits into sticky death flags.
//
// state | meaning
// IDLE  | waiting for frame_start && enable; rom_addr parked at 0
// SCAN  | issuing lookup 3c+p, one per cycle, accumulating returned colours
// DRAIN | last ROM word returns; results committed at the edge leaving it
module hazard_scanner #(
  parameter int          NUM_CHAR = 2,
  parameter int          PROBE_DX = 8,
  parameter int          PROBE_DY = 4,
  parameter int          MAP_W    = 200,
  parameter int          ADDR_W   = 17,
  parameter int          DEBOUNCE = 2,
  parameter logic [23:0] LAVA_C   = 24'hac0404,
  parameter logic [23:0] WATER_C  = 24'h4face5,
  parameter logic [23:0] GOO_C    = 24'h69a42a
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic                  enable,
  input  logic                  clear_dead,
  input  logic [NUM_CHAR*10-1:0] char_x,
  input  logic [NUM_CHAR*10-1:0] char_y,
  input  logic [NUM_CHAR*7-1:0]  char_h,
  input  logic [NUM_CHAR*3-1:0]  kill_mask,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [23:0]            rom_data,
  output logic [NUM_CHAR-1:0]    is_dead,
  output logic                   any_dead,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [10:0] DX  = 11'(PROBE_DX);
  localparam logic [10:0] DY  = 11'(PROBE_DY);
  localparam logic [2:0]  DEB = 3'(DEBOUNCE);

  state_t                 state_q, state_d;
  logic [1:0]             c_q, c_d, p_q, p_d, c_n, p_n;
  logic [NUM_CHAR*10-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [NUM_CHAR*7-1:0]  snap_h_q, snap_h_d;
  logic [NUM_CHAR*3-1:0]  snap_km_q, snap_km_d;
  logic [NUM_CHAR-1:0]    hit_q, hit_d, hit_acc;
  logic                   pend_v_q, pend_v_d;
  logic [1:0]             pend_c_q, pend_c_d;
  logic [2:0]             cnt_q [NUM_CHAR];
  logic [2:0]             cnt_d [NUM_CHAR];
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [NUM_CHAR-1:0]    is_dead_q, is_dead_d;
  logic                   any_dead_q, any_dead_d;
  logic                   scan_busy_q, scan_busy_d;
  logic                   scan_done_q, scan_done_d;
  logic                   overrun_q, overrun_d;
  logic [2:0]             cls;
  logic                   last;
  logic [9:0]             sel_x, sel_y;
  logic [6:0]             sel_h;

  // Map-ROM address of one probe; all arithmetic is wide enough that nothing wraps.
  function automatic logic [ADDR_W-1:0] probe_addr(input logic [9:0] x, input logic [9:0] y,
                                                   input logic [6:0] h, input logic [1:0] p);
    logic [10:0] yb, ys, px, py, xw;
    logic [19:0] a;
    yb = {1'b0, y} + ({4'b0, h} >> 1);
    if (yb > 11'd479) yb = 11'd479;
    ys = (yb >= DY) ? yb - DY : 11'd0;
    xw = {1'b0, x};
    case (p)
      2'd0:    begin px = xw; py = yb; end
      2'd1:    begin px = (xw >= DX) ? xw - DX : 11'd0; py = ys; end
      default: begin px = (xw + DX > 11'd639) ? 11'd639 : xw + DX; py = ys; end
    endcase
    a = ((20'(px) * 20'd5) >> 4) + ((20'(py) * 20'd5) >> 4) * 20'(MAP_W);
    return ADDR_W'(a);
  endfunction

  // Next-state, lookup sequencing, hit accumulation and commit.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    p_d         = p_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_h_d    = snap_h_q;
    snap_km_d   = snap_km_q;
    pend_v_d    = 1'b0;
    pend_c_d    = c_q;
    cnt_d       = cnt_q;
    is_dead_d   = is_dead_q;
    rom_addr_d  = '0;
    scan_done_d = 1'b0;
    overrun_d   = 1'b0;

    cls = {rom_data == GOO_C, rom_data == WATER_C, rom_data == LAVA_C};

    // The word returning this cycle belongs to the lookup issued last cycle.
    hit_acc = hit_q;
    for (int c = 0; c < NUM_CHAR; c++)
      if (pend_v_q && pend_c_q == 2'(c))
        hit_acc[c] = hit_acc[c] | (|(cls & snap_km_q[3*c +: 3]));
    hit_d = hit_acc;

    last = (c_q == 2'(NUM_CHAR-1)) && (p_q == 2'd2);
    if (p_q == 2'd2) begin
      c_n = c_q + 2'd1;
      p_n = 2'd0;
    end else begin
      c_n = c_q;
      p_n = p_q + 2'd1;
    end
    sel_x = '0;
    sel_y = '0;
    sel_h = '0;
    for (int c = 0; c < NUM_CHAR; c++)
      if (c_n == 2'(c)) begin
        sel_x = snap_x_q[10*c +: 10];
        sel_y = snap_y_q[10*c +: 10];
        sel_h = snap_h_q[7*c +: 7];
      end

    case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          state_d    = SCAN;
          snap_x_d   = char_x;
          snap_y_d   = char_y;
          snap_h_d   = char_h;
          snap_km_d  = kill_mask;
          c_d        = 2'd0;
          p_d        = 2'd0;
          hit_d      = '0;
          rom_addr_d = probe_addr(char_x[9:0], char_y[9:0], char_h[6:0], 2'd0);
        end
      end
      SCAN: begin
        pend_v_d  = 1'b1;
        overrun_d = frame_start;
        if (last) begin
          state_d = DRAIN;
        end else begin
          c_d        = c_n;
          p_d        = p_n;
          rom_addr_d = probe_addr(sel_x, sel_y, sel_h, p_n);
        end
      end
      DRAIN: begin
        state_d     = IDLE;
        overrun_d   = frame_start;
        scan_done_d = 1'b1;
        for (int c = 0; c < NUM_CHAR; c++) begin
          if (!enable || !hit_acc[c]) begin
            cnt_d[c] = 3'd0;
          end else begin
            cnt_d[c] = (cnt_q[c] >= DEB) ? DEB : cnt_q[c] + 3'd1;
            if (cnt_d[c] == DEB) is_dead_d[c] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_dead) begin
      is_dead_d = '0;
      for (int c = 0; c < NUM_CHAR; c++) cnt_d[c] = 3'd0;
    end

    scan_busy_d = (state_d != IDLE);
    any_dead_d  = |is_dead_d;
  end

  // All state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      c_q         <= '0;
      p_q         <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_h_q    <= '0;
      snap_km_q   <= '0;
      hit_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_c_q    <= '0;
      for (int c = 0; c < NUM_CHAR; c++) cnt_q[c] <= 3'd0;
      rom_addr_q  <= '0;
      is_dead_q   <= '0;
      any_dead_q  <= 1'b0;
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      p_q         <= p_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_h_q    <= snap_h_d;
      snap_km_q   <= snap_km_d;
      hit_q       <= hit_d;
      pend_v_q    <= pend_v_d;
      pend_c_q    <= pend_c_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      is_dead_q   <= is_dead_d;
      any_dead_q  <= any_dead_d;
      scan_busy_q <= scan_busy_d;
      scan_done_q <= scan_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign is_dead   = is_dead_q;
  assign any_dead  = any_dead_q;
  assign scan_busy = scan_busy_q;
  assign scan_done = scan_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hazard_scanner.sv
// Bench for hazard_scanner: directed scenarios plus randomized frames,
// checked against a frame-level reference model.
module tb_hazard_scanner;
  localparam int          NC    = 2;
  localparam logic [23:0] LAVA  = 24'hac0404;
  localparam logic [23:0] WATER = 24'h4face5;
  localparam logic [23:0] GOO   = 24'h69a42a;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start, enable, clear_dead;
  logic [19:0] char_x, char_y;
  logic [13:0] char_h;
  logic [5:0]  kill_mask;
  logic [16:0] rom_addr;
  logic [23:0] rom_data = 24'h0;
  logic [1:0]  is_dead;
  logic        any_dead, scan_busy, scan_done, overrun;

  hazard_scanner dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enable(enable),
    .clear_dead(clear_dead), .char_x(char_x), .char_y(char_y), .char_h(char_h),
    .kill_mask(kill_mask), .rom_addr(rom_addr), .rom_data(rom_data),
    .is_dead(is_dead), .any_dead(any_dead), .scan_busy(scan_busy),
    .scan_done(scan_done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Synchronous map ROM; unlisted addresses read as a safe colour.
  logic [23:0] rom_map [int];
  always @(posedge Clk)
    rom_data <= rom_map.exists(int'(rom_addr)) ? rom_map[int'(rom_addr)] : 24'h000000;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt [NC];
  bit m_dead [NC];
  int exp_addr [3*NC];
  int obs_addr [3*NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_addr(input int x, input int y, input int h, input int p);
    int yb, px, py;
    yb = y + h / 2;
    if (yb > 479) yb = 479;
    if (p == 0) begin
      px = x; py = yb;
    end else begin
      py = (yb >= 4) ? yb - 4 : 0;
      if (p == 1) px = (x >= 8) ? x - 8 : 0;
      else        px = (x + 8 > 639) ? 639 : x + 8;
    end
    return ((px * 5) / 16 + ((py * 5) / 16) * 200) % 131072;
  endfunction

  function automatic int m_class(input logic [23:0] col);
    if (col == LAVA)  return 1;
    if (col == WATER) return 2;
    if (col == GOO)   return 4;
    return 0;
  endfunction

  task automatic m_predict(output bit [NC-1:0] hit);
    int a, km;
    logic [23:0] col;
    hit = '0;
    for (int c = 0; c < NC; c++) begin
      km = int'(kill_mask[3*c +: 3]);
      for (int p = 0; p < 3; p++) begin
        a = m_addr(int'(char_x[10*c +: 10]), int'(char_y[10*c +: 10]), int'(char_h[7*c +: 7]), p);
        exp_addr[3*c+p] = a;
        col = rom_map.exists(a) ? rom_map[a] : 24'h0;
        if ((m_class(col) & km) != 0) hit[c] = 1'b1;
      end
    end
  endtask

  task automatic m_commit(input bit [NC-1:0] hit, input bit clr);
    for (int c = 0; c < NC; c++) begin
      if (clr) begin
        m_cnt[c] = 0; m_dead[c] = 0;
      end else if (hit[c]) begin
        m_cnt[c] = (m_cnt[c] + 1 > 2) ? 2 : m_cnt[c] + 1;
        if (m_cnt[c] == 2) m_dead[c] = 1;
      end else begin
        m_cnt[c] = 0;
      end
    end
  endtask

  function automatic logic [1:0] dead_vec();
    return {m_dead[1], m_dead[0]};
  endfunction

  task automatic set_char(input int c, input int x, input int y, input int h, input int km);
    char_x[10*c +: 10]  = 10'(x);
    char_y[10*c +: 10]  = 10'(y);
    char_h[7*c +: 7]    = 7'(h);
    kill_mask[3*c +: 3] = 3'(km);
  endtask

  task automatic do_clear();
    clear_dead = 1'b1;
    @(negedge Clk);
    clear_dead = 1'b0;
    m_commit('0, 1'b1);
  endtask

  // One frame, starting at a negedge in cycle 0. inj_fs: cycle in which an
  // extra frame_start is driven (0 = none); clr: clear_dead at the commit edge.
  task automatic run_frame(input int inj_fs, input bit clr, input bit scramble);
    bit [NC-1:0] hit;
    m_predict(hit);
    frame_start = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge Clk);
      if (cyc <= 3*NC) begin
        obs_addr[cyc-1] = int'(rom_addr);
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr[cyc-1]));
      end
      if (cyc == 9) chk("rom_addr_idle", 32'(rom_addr), 32'd0);
      chk("scan_busy", 32'(scan_busy), 32'(cyc <= 3*NC+1));
      chk("scan_done", 32'(scan_done), 32'(cyc == 3*NC+2));
      chk("overrun", 32'(overrun), 32'(inj_fs > 0 && cyc == inj_fs + 1));
      if (cyc == 3*NC+2) begin
        m_commit(hit, clr);
        chk("is_dead", 32'(is_dead), 32'(dead_vec()));
        chk("any_dead", 32'(any_dead), 32'(|dead_vec()));
      end
      frame_start = (cyc == inj_fs);
      clear_dead  = clr && (cyc == 3*NC+1);
      if (scramble && cyc == 2) begin
        char_x = 20'($urandom); char_y = 20'($urandom);
        char_h = 14'($urandom); kill_mask = 6'($urandom);
      end
    end
    frame_start = 1'b0;
    clear_dead  = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; enable = 1'b1; clear_dead = 1'b0;
    char_x = '0; char_y = '0; char_h = '0; kill_mask = '0;
    for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_dead[c] = 0; end
    repeat (2) @(negedge Clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_is_dead", 32'(is_dead), 32'd0);
    chk("rst_any_dead", 32'(any_dead), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_done", 32'(scan_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Address generation
    set_char(0, 100, 200, 32, 0);
    set_char(1, 300, 100, 20, 7);
    run_frame(0, 0, 0);
    chk("addr_p0", 32'(obs_addr[0]), 32'd13431);
    chk("addr_p1", 32'(obs_addr[1]), 32'd13228);
    chk("addr_p2", 32'(obs_addr[2]), 32'd13233);

    // Debounce over two frames
    rom_map[13431] = LAVA;
    set_char(0, 100, 200, 32, 1);
    set_char(1, 300, 100, 20, 0);
    run_frame(0, 0, 0);
    chk("deb_f1", 32'(is_dead), 32'd0);
    run_frame(0, 0, 0);
    chk("deb_f2", 32'(is_dead), 32'd1);
    chk("deb_any", 32'(any_dead), 32'd1);

    // Reset in cycle 3 of a scan
    frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_is_dead", 32'(is_dead), 32'd0);
    chk("mid_rst_any_dead", 32'(any_dead), 32'd0);
    chk("mid_rst_busy", 32'(scan_busy), 32'd0);
    chk("mid_rst_done", 32'(scan_done), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_dead[c] = 0; end
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    run_frame(0, 0, 0);
    chk("post_rst_dead", 32'(is_dead), 32'd0);

    // clear_dead at the commit edge beats the killing commit
    run_frame(0, 1, 0);
    chk("clr_commit_dead", 32'(is_dead), 32'd0);

    // Interrupted hit: lava, safe, lava
    run_frame(0, 0, 0);
    rom_map.delete();
    run_frame(0, 0, 0);
    rom_map[13431] = LAVA;
    run_frame(0, 0, 0);
    chk("interrupted_dead", 32'(is_dead), 32'd0);

    // Mask selectivity: water under a lava-only mask
    rom_map.delete();
    rom_map[13431] = WATER; rom_map[13228] = WATER; rom_map[13233] = WATER;
    repeat (3) run_frame(0, 0, 0);
    chk("mask_dead", 32'(is_dead), 32'd0);

    // frame_start during SCAN
    run_frame(4, 0, 0);

    // Clamping at the map edges
    set_char(0, 3, 0, 4, 7);
    set_char(1, 636, 470, 100, 7);
    run_frame(0, 0, 0);
    chk("clamp_left", 32'(obs_addr[1]), 32'd0);
    chk("clamp_right0", 32'(obs_addr[2]), 32'd3);
    chk("clamp_right1", 32'(obs_addr[5]), 32'd29799);

    // Randomized frames
    do_clear();
    for (int f = 0; f < 12; f++) begin
      rom_map.delete();
      for (int c = 0; c < NC; c++)
        set_char(c, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 127), $urandom_range(0, 7));
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < 3; p++) begin
          int a;
          a = m_addr(int'(char_x[10*c +: 10]), int'(char_y[10*c +: 10]), int'(char_h[7*c +: 7]), p);
          case ($urandom_range(0, 4))
            0: rom_map[a] = LAVA;
            1: rom_map[a] = WATER;
            2: rom_map[a] = GOO;
            3: rom_map[a] = 24'h123456;
            default: ;
          endcase
        end
      run_frame(0, 0, f[0]);
      if (f % 5 == 4) do_clear();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scanner.md
# hazard_scanner

Sequential, parametrised hazard detector for the level-map collision path. Once per frame it probes a small set of map points around each character's feet through one shared synchronous map ROM port. Each sampled colour is classified as lava, water, goo or safe. Each class is checked against a per-character kill mask. A character's sticky death flag is set only after the hit persists for a configurable number of consecutive frames. The block sits between the character position registers and the game-status FSM.

## Interface
Parameters:
- NUM_CHAR, 2: number of characters scanned per frame (1..4).
- PROBE_DX, 8: horizontal offset of side probes, pixels.
- PROBE_DY, 4: upward offset of side probes, pixels.
- MAP_W, 200: map ROM row pitch, words.
- ADDR_W, 17: ROM address width.
- DEBOUNCE, 2: consecutive hit frames required to kill (1..7).
- LAVA_C, 24'hac0404; WATER_C, 24'h4face5; GOO_C, 24'h69a42a: hazard colours.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- enable  in  1  game in play; scans start only when high.
- clear_dead  in  1  clears is_dead and debounce counters.
- char_x  in  NUM_CHAR*10  centre x per character, char c at [10c+9:10c].
- char_y  in  NUM_CHAR*10  centre y per character.
- char_h  in  NUM_CHAR*7  sprite height per character.
- kill_mask  in  NUM_CHAR*3  per character, bit0 lava, bit1 water, bit2 goo.
- rom_addr  out  ADDR_W  registered map ROM address.
- rom_data  in  24  ROM colour; valid exactly one cycle after rom_addr.
- is_dead  out  NUM_CHAR  sticky per-character death flag.
- any_dead  out  1  OR of is_dead, registered.
- scan_busy  out  1  high while in SCAN or DRAIN.
- scan_done  out  1  one-cycle pulse when results are committed.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

## Operation
- FSM has three states: IDLE, SCAN and DRAIN.
- IDLE→SCAN on frame_start && enable:
  - char_x, char_y, char_h and kill_mask are snapshotted.
  - Lookup index i is cleared.
- SCAN issues lookup i = 3c+p, with p=0 bottom, p=1 left, p=2 right.
- After i = 3·NUM_CHAR−1, SCAN→DRAIN; DRAIN→IDLE after one cycle.
- Probe coordinates:
  - yb = min(y + (h>>1), 479).
  - p0: (x, yb).
  - p1: (x≥DX ? x−DX : 0, yb≥DY ? yb−DY : 0).
  - p2: (min(x+DX, 639), same y as p1).
- Address = ((px·5)>>4) + ((py·5)>>4)·MAP_W.
  - Computed at 20 bits, then truncated to ADDR_W.
  - No 10-bit wraparound anywhere.
- rom_data returned in each cycle is compared exactly against the three colours.
  - hit[c] |= (class bit & kill_mask[c]).
  - hit vector clears at scan start.
- Commit happens at the edge ending DRAIN, per character:
  - If hit, cnt[c] = min(cnt+1, DEBOUNCE); otherwise cnt[c] = 0.
  - is_dead[c] sets when the new cnt == DEBOUNCE.
  - is_dead never clears except on clear_dead or Reset.
- If enable is low at the commit edge, nothing is committed: counters are zeroed and scan_done is still pulsed.
- clear_dead zeroes is_dead and cnt in any state. It takes priority over a simultaneous commit.
- A frame_start in SCAN/DRAIN is ignored and pulses overrun. The running scan is unaffected.
- Reset (any time, including mid-scan):
  - State goes to IDLE.
  - rom_addr, is_dead, any_dead, cnt, hit, scan_busy, scan_done and overrun all go to 0.

## Timing
- frame_start sampled at the edge ending cycle 0. rom_addr holds lookup k in cycle k+1, for k = 0..3·NUM_CHAR−1.
- rom_data for lookup k is valid in cycle k+2. It is accumulated at the edge ending that cycle.
- DRAIN is cycle 3·NUM_CHAR+1. is_dead, any_dead and scan_done update in cycle 3·NUM_CHAR+2 (cycle 8 for NUM_CHAR=2).
- scan_busy is high in cycles 1..3·NUM_CHAR+1.
- A back-to-back frame_start is accepted in the scan_done cycle.
- rom_addr returns to 0 in IDLE.

## Test plan
- Address generation: char0 x=100, y=200, h=32 → rom_addr 13431, 13228, 13233 in cycles 1..3.
- Debounce: DEBOUNCE=2, ROM returns LAVA_C at 13431, kill_mask0=3'b001, 2 frames:
  - Frame 1: scan_done in cycle 8, is_dead=2'b00.
  - Frame 2: is_dead=2'b01, any_dead=1.
- Mask selectivity: WATER_C on char0 probes, kill_mask0=3'b001, 3 frames → is_dead stays 0.
- Hit interrupted: LAVA on frames 1 and 3, safe on frame 2 → cnt resets, is_dead=0 after frame 3.
- Clamping: x=3, yb=2 → side probe px=0, py=0; x=636 → px=639; no address wrap.
- Control boundaries, each checked separately:
  - frame_start in cycle 4 → overrun pulse, single scan_done.
  - clear_dead at the commit edge → is_dead=0.
  - Reset in cycle 3 → all outputs 0, next frame_start restarts cleanly.
